regfile_mp_sb: RTL and testbench

//  Parametrised multi-port register file: NUM_RD read ports, two write ports, optional hardwired zero register.

---
 rtl/regfile_mp_sb_pkg.sv | 16 +
 rtl/regfile_mp_sb_if.sv | 36 +++
 rtl/regfile_mp_sb_read_port.sv | 43 ++++
 rtl/regfile_mp_sb.sv | 85 ++++++++
 tb/tb_regfile_mp_sb.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/regfile_mp_sb_pkg.sv
// Shared defaults and helpers for the multi-port register file.
package regfile_mp_sb_pkg;

  localparam int DEF_DW     = 8;
  localparam int DEF_DEPTH  = 32;
  localparam int DEF_NUM_RD = 2;

  // Address of the optional hardwired-zero register.
  localparam int REG_ZERO   = 0;

  // Address width for a power-of-two register count.
  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/regfile_mp_sb_if.sv
// Register-file bus: two write ports, packed read ports, scoreboard set and debug view.
interface regfile_mp_sb_if
  import regfile_mp_sb_pkg::*;
#(
  parameter int DW     = DEF_DW,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int NUM_RD = DEF_NUM_RD
);
  localparam int AW = addr_w(DEPTH);

  logic                 we0;
  logic [AW-1:0]        waddr0;
  logic [DW-1:0]        wdata0;
  logic                 we1;
  logic [AW-1:0]        waddr1;
  logic [DW-1:0]        wdata1;
  logic [NUM_RD*AW-1:0] raddr;
  logic [NUM_RD*DW-1:0] rdata;
  logic [NUM_RD-1:0]    rbusy;
  logic                 sb_set;
  logic [AW-1:0]        sb_addr;
  logic [DEPTH-1:0]     busy_vec;

  // Decode/operand-fetch side.
  modport master (
    output we0, waddr0, wdata0, we1, waddr1, wdata1, raddr, sb_set, sb_addr,
    input  rdata, rbusy, busy_vec
  );

  // Register-file side.
  modport slave (
    input  we0, waddr0, wdata0, we1, waddr1, wdata1, raddr, sb_set, sb_addr,
    output rdata, rbusy, busy_vec
  );

endinterface

// File: rtl/regfile_mp_sb_read_port.sv
// One read port: array row, optional same-cycle bypass, zero-register masking.
module regfile_mp_sb_read_port
  import regfile_mp_sb_pkg::*;
#(
  parameter int DW       = DEF_DW,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic [AW-1:0] raddr,
  input  logic [DW-1:0] row,
  input  logic          busy,
  input  logic          we0,
  input  logic [AW-1:0] waddr0,
  input  logic [DW-1:0] wdata0,
  input  logic          we1,
  input  logic [AW-1:0] waddr1,
  input  logic [DW-1:0] wdata1,
  output logic [DW-1:0] rdata,
  output logic          rbusy
);

  // Port 1 bypass beats port 0; a bypassed value is the fresh result, so it is
  // never reported busy. The zero register overrides everything.
  always_comb begin
    rdata = row;
    rbusy = busy;
    if (BYPASS != 0) begin
      if (we1 && waddr1 == raddr) begin
        rdata = wdata1;
        rbusy = 1'b0;
      end else if (we0 && waddr0 == raddr) begin
        rdata = wdata0;
        rbusy = 1'b0;
      end
    end
    if (ZERO_REG != 0 && raddr == AW'(REG_ZERO)) begin
      rdata = '0;
      rbusy = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with two write ports and a busy scoreboard.
module regfile_mp_sb
  import regfile_mp_sb_pkg::*;
#(
  parameter int DW       = DEF_DW,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic           clk,
  input  logic           rst,
  regfile_mp_sb_if.slave bus
);
  localparam int AW = addr_w(DEPTH);

  logic [DEPTH-1:0][DW-1:0]  regs;
  logic [DEPTH-1:0]          busy;
  logic [DEPTH-1:0]          busy_nxt;
  logic [NUM_RD-1:0][AW-1:0] ra;
  logic [NUM_RD-1:0][DW-1:0] rd;
  logic [NUM_RD-1:0]         rb;
  logic                      w0_en;
  logic                      w1_en;

  // Writes to the zero register are dropped; on an address collision port 1 wins,
  // so port 0 is simply suppressed rather than relying on assignment order.
  assign w1_en = bus.we1 && !(ZERO_REG != 0 && bus.waddr1 == AW'(REG_ZERO));
  assign w0_en = bus.we0 && !(ZERO_REG != 0 && bus.waddr0 == AW'(REG_ZERO))
                 && !(bus.we1 && bus.waddr1 == bus.waddr0);

  // Register array update.
  always_ff @(posedge clk) begin
    if (rst) begin
      regs <= '0;
    end else begin
      if (w0_en) regs[bus.waddr0] <= bus.wdata0;
      if (w1_en) regs[bus.waddr1] <= bus.wdata1;
    end
  end

  // Scoreboard next state: a newly issued producer outranks a retiring write.
  always_comb begin
    busy_nxt = busy;
    for (int r = 0; r < DEPTH; r++) begin
      if (bus.sb_set && bus.sb_addr == AW'(r) && !(ZERO_REG != 0 && r == REG_ZERO))
        busy_nxt[r] = 1'b1;
      else if ((bus.we0 && bus.waddr0 == AW'(r)) || (bus.we1 && bus.waddr1 == AW'(r)))
        busy_nxt[r] = 1'b0;
    end
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (rst) busy <= '0;
    else     busy <= busy_nxt;
  end

  assign bus.busy_vec = busy;
  assign ra           = bus.raddr;
  assign bus.rdata    = rd;
  assign bus.rbusy    = rb;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    regfile_mp_sb_read_port #(
      .DW       (DW),
      .AW       (AW),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS)
    ) u_rp (
      .raddr  (ra[k]),
      .row    (regs[ra[k]]),
      .busy   (busy[ra[k]]),
      .we0    (bus.we0),
      .waddr0 (bus.waddr0),
      .wdata0 (bus.wdata0),
      .we1    (bus.we1),
      .waddr1 (bus.waddr1),
      .wdata1 (bus.wdata1),
      .rdata  (rd[k]),
      .rbusy  (rb[k])
    );
  end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed bench for regfile_mp_sb: 4 read ports, zero register and bypass enabled.
module tb_regfile_mp_sb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  regfile_mp_sb_if #(.DW(8), .DEPTH(32), .NUM_RD(4)) bus ();

  regfile_mp_sb #(
    .DW(8), .DEPTH(32), .NUM_RD(4), .ZERO_REG(1), .BYPASS(1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rd(input int k);
    return bus.rdata[k*8 +: 8];
  endfunction

  task automatic set_raddr(input logic [4:0] a0, a1, a2, a3);
    bus.raddr = {a3, a2, a1, a0};
  endtask

  task automatic idle();
    bus.we0 = 1'b0; bus.waddr0 = '0; bus.wdata0 = '0;
    bus.we1 = 1'b0; bus.waddr1 = '0; bus.wdata1 = '0;
    bus.sb_set = 1'b0; bus.sb_addr = '0;
  endtask

  initial begin
    idle();
    set_raddr(5'd3, 5'd5, 5'd7, 5'd9);
    tick();
    rst = 1'b0;

    // Fill some registers and mark r9 busy before the reset under test.
    bus.we0 = 1'b1; bus.waddr0 = 5'd3; bus.wdata0 = 8'h12;
    bus.we1 = 1'b1; bus.waddr1 = 5'd5; bus.wdata1 = 8'h34;
    bus.sb_set = 1'b1; bus.sb_addr = 5'd9;
    tick();
    bus.waddr0 = 5'd7; bus.wdata0 = 8'h56;
    bus.waddr1 = 5'd9; bus.wdata1 = 8'h78;
    bus.sb_set = 1'b1; bus.sb_addr = 5'd9;
    tick();
    idle();
    #1;
    chk("prefill_r3", rd(0), 8'h12);
    chk("prefill_r9", rd(3), 8'h78);
    chk("prefill_busy9", bus.busy_vec, 64'h200);

    // Reset with a write and a scoreboard set in the same cycle: both discarded.
    rst = 1'b1;
    bus.we0 = 1'b1; bus.waddr0 = 5'd3; bus.wdata0 = 8'hAA;
    bus.sb_set = 1'b1; bus.sb_addr = 5'd5;
    tick();
    rst = 1'b0;
    idle();
    #1;
    chk("rst_rdata", bus.rdata, 32'h0);
    chk("rst_rbusy", bus.rbusy, 4'h0);
    chk("rst_busy_vec", bus.busy_vec, 64'h0);

    // Single write with same-cycle bypass, then array read.
    set_raddr(5'd5, 5'd5, 5'd1, 5'd1);
    bus.we0 = 1'b1; bus.waddr0 = 5'd5; bus.wdata0 = 8'h3C;
    #1;
    chk("byp_r5_p0", rd(0), 8'h3C);
    chk("byp_r1_p2_unaffected", rd(2), 8'h00);
    tick();
    idle();
    #1;
    chk("arr_r5_p1", rd(1), 8'h3C);

    // Collision: port 1 wins both in bypass and in the array.
    set_raddr(5'd5, 5'd5, 5'd7, 5'd1);
    bus.we0 = 1'b1; bus.waddr0 = 5'd7; bus.wdata0 = 8'h11;
    bus.we1 = 1'b1; bus.waddr1 = 5'd7; bus.wdata1 = 8'h22;
    #1;
    chk("coll_byp_r7", rd(2), 8'h22);
    tick();
    idle();
    #1;
    chk("coll_arr_r7", rd(2), 8'h22);

    // Zero register: write and scoreboard set both ignored.
    set_raddr(5'd5, 5'd5, 5'd7, 5'd0);
    bus.we1 = 1'b1; bus.waddr1 = 5'd0; bus.wdata1 = 8'hFF;
    bus.sb_set = 1'b1; bus.sb_addr = 5'd0;
    #1;
    chk("zero_byp_r0", rd(3), 8'h00);
    tick();
    idle();
    #1;
    chk("zero_arr_r0", rd(3), 8'h00);
    chk("zero_busy_vec", bus.busy_vec, 64'h0);
    chk("zero_rbusy", bus.rbusy[3], 1'b0);

    // Scoreboard set then cleared by the producer's write.
    bus.sb_set = 1'b1; bus.sb_addr = 5'd9;
    tick();
    idle();
    set_raddr(5'd9, 5'd5, 5'd7, 5'd0);
    #1;
    chk("sb9_rbusy", bus.rbusy, 4'b0001);
    chk("sb9_busy_vec", bus.busy_vec, 64'h200);
    bus.we0 = 1'b1; bus.waddr0 = 5'd9; bus.wdata0 = 8'h5A;
    #1;
    chk("sb9_wr_byp_data", rd(0), 8'h5A);
    chk("sb9_wr_byp_rbusy", bus.rbusy[0], 1'b0);
    tick();
    idle();
    #1;
    chk("sb9_after_rbusy", bus.rbusy[0], 1'b0);
    chk("sb9_after_data", rd(0), 8'h5A);
    chk("sb9_after_busy_vec", bus.busy_vec, 64'h0);

    // Independent writes on both ports to different registers.
    bus.we0 = 1'b1; bus.waddr0 = 5'd10; bus.wdata0 = 8'hA1;
    bus.we1 = 1'b1; bus.waddr1 = 5'd11; bus.wdata1 = 8'hB2;
    tick();
    idle();
    set_raddr(5'd10, 5'd11, 5'd5, 5'd7);
    #1;
    chk("indep_rdata", bus.rdata, 32'h22_3C_B2_A1);

    // Set and write on the same register: set wins, data still stored.
    set_raddr(5'd10, 5'd3, 5'd5, 5'd7);
    bus.sb_set = 1'b1; bus.sb_addr = 5'd3;
    bus.we0 = 1'b1; bus.waddr0 = 5'd3; bus.wdata0 = 8'h77;
    #1;
    chk("setwr_byp_data", rd(1), 8'h77);
    chk("setwr_byp_rbusy", bus.rbusy[1], 1'b0);
    tick();
    idle();
    #1;
    chk("setwr_busy_vec", bus.busy_vec, 64'h8);
    chk("setwr_rbusy", bus.rbusy, 4'b0010);
    chk("setwr_data", rd(1), 8'h77);

    // Mid-sequence reset clears both the register and its busy bit.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("midrst_busy_vec", bus.busy_vec, 64'h0);
    chk("midrst_r3", rd(1), 8'h00);
    chk("midrst_rdata_all", bus.rdata, 32'h0);
    chk("midrst_rbusy", bus.rbusy, 4'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
